// File: rtl/idec_pkg.sv
// Shared types and helpers for the idec_stream instruction decode stage.
// Field widths here set the storage format of a decoded entry; the
// decode stage checks at elaboration that its own widths agree.
package idec_pkg;

    localparam int unsigned IDEC_OP_W   = 3;
    localparam int unsigned IDEC_ADDR_W = 5;
    localparam int unsigned IDEC_OH_W   = 1 << IDEC_OP_W;

    typedef logic [IDEC_OP_W-1:0]   opcode_t;
    typedef logic [IDEC_ADDR_W-1:0] addr_t;
    typedef logic [IDEC_OH_W-1:0]   onehot_t;

    typedef struct packed {
        opcode_t opcode;
        addr_t   addr;
        onehot_t onehot;
    } dec_entry_t;

    // One-hot of an opcode; all-zero when the opcode is not below num_ops.
    function automatic onehot_t onehot_of(input opcode_t op, input int unsigned num_ops);
        onehot_t oh;
        oh = '0;
        if (32'(op) < num_ops) begin
            oh[op] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/idec_skid_buf.sv
// Two-entry valid/ready buffer of decoded entries.
// Head/tail pointers plus an occupancy counter; the head entry is read
// straight from storage so it stays stable while the consumer stalls.
module idec_skid_buf
    import idec_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  dec_entry_t i_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_valid,
    output dec_entry_t o_head
);

    dec_entry_t r_mem [2];
    logic       r_head;
    logic       r_tail;
    logic [1:0] r_occ;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_occ == 2'd2);
    assign o_valid = (r_occ != 2'd0);
    assign o_head  = r_mem[r_head];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && o_valid;

    // Storage, pointers and occupancy; reset clears contents so fields read zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/idec_stream.sv
// Flow-controlled instruction decode stage: splits each instruction into
// opcode/address, adds a one-hot opcode, counts accepted instructions and
// buffers results in a 2-entry skid buffer.
// Optional feature macro: IDEC_ILLEGAL_TRAP_EN (sticky illegal-opcode trap).
module idec_stream
    import idec_pkg::*;
#(
    parameter int unsigned OP_W    = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned NUM_OPS = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    opcode,
    output logic [ADDR_W-1:0]  addr,
    output logic [NUM_OPS-1:0] op_onehot,
    output logic [CNT_W-1:0]   dec_count
`ifdef IDEC_ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

    if (INSTR_W != OP_W + ADDR_W) begin : g_bad_instr_w
        $error("idec_stream: INSTR_W must equal OP_W+ADDR_W");
    end
    if (OP_W != IDEC_OP_W || ADDR_W != IDEC_ADDR_W) begin : g_bad_field_w
        $error("idec_stream: OP_W/ADDR_W must match idec_pkg entry format");
    end
    if (NUM_OPS < 1 || NUM_OPS > (1 << OP_W)) begin : g_bad_num_ops
        $error("idec_stream: NUM_OPS must be in 1..2**OP_W");
    end

    opcode_t          w_op;
    addr_t            w_addr;
    dec_entry_t       w_entry;
    dec_entry_t       w_head;
    logic             w_full;
    logic             w_accept;
    logic             w_pop;
    logic             w_trap_block;
    logic [CNT_W-1:0] r_count;

    assign w_op   = instruction[INSTR_W-1 -: OP_W];
    assign w_addr = instruction[ADDR_W-1:0];

    // Build the decoded entry for the incoming word.
    always_comb begin
        w_entry        = '0;
        w_entry.opcode = w_op;
        w_entry.addr   = w_addr;
        w_entry.onehot = onehot_of(w_op, NUM_OPS);
    end

    assign in_ready = en && !w_full && !w_trap_block;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    idec_skid_buf u_buf (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_accept),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (out_valid),
        .o_head  (w_head)
    );

    assign opcode    = w_head.opcode;
    assign addr      = w_head.addr;
    assign op_onehot = w_head.onehot[NUM_OPS-1:0];
    assign dec_count = r_count;

    // Count every accepted instruction; wraps silently.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef IDEC_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_illegal_op;

    assign w_illegal_op = (32'(w_op) >= NUM_OPS);

    // Sticky trap on accepting an out-of-range opcode; only reset clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (w_accept && w_illegal_op) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal      = r_illegal;
    assign w_trap_block = r_illegal;
`else
    assign w_trap_block = 1'b0;
`endif

endmodule

// File: tb/tb_idec_stream.sv
// Directed self-checking bench for idec_stream. Two instances share the
// stimulus: u_d with default parameters, u_c with CNT_W=4, NUM_OPS=6.
module tb_idec_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [7:0] instr;
    logic       out_ready;

    logic       d_in_ready, d_out_valid;
    logic [2:0] d_opcode;
    logic [4:0] d_addr;
    logic [7:0] d_onehot;
    logic [15:0] d_count;

    logic       c_in_ready, c_out_valid;
    logic [2:0] c_opcode;
    logic [4:0] c_addr;
    logic [5:0] c_onehot;
    logic [3:0] c_count;

`ifdef IDEC_ILLEGAL_TRAP_EN
    logic d_illegal, c_illegal;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    idec_stream u_d (
        .clock       (clk),
        .reset       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (d_in_ready),
        .instruction (instr),
        .out_valid   (d_out_valid),
        .out_ready   (out_ready),
        .opcode      (d_opcode),
        .addr        (d_addr),
        .op_onehot   (d_onehot),
        .dec_count   (d_count)
`ifdef IDEC_ILLEGAL_TRAP_EN
        ,
        .illegal     (d_illegal)
`endif
    );

    idec_stream #(.CNT_W(4), .NUM_OPS(6)) u_c (
        .clock       (clk),
        .reset       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (c_in_ready),
        .instruction (instr),
        .out_valid   (c_out_valid),
        .out_ready   (out_ready),
        .opcode      (c_opcode),
        .addr        (c_addr),
        .op_onehot   (c_onehot),
        .dec_count   (c_count)
`ifdef IDEC_ILLEGAL_TRAP_EN
        ,
        .illegal     (c_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        en       = 1'b1;
        tick();
        rst_n    = 1'b1;
    endtask

    initial begin
        // 1: reset held 3 cycles with traffic offered
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; instr = 8'hA7; out_ready = 1'b1;
        #1;
        tick(); tick(); tick();
        chk("rst_out_valid", 32'(d_out_valid), 32'd0);
        chk("rst_count",     32'(d_count),     32'd0);
        chk("rst_opcode",    32'(d_opcode),    32'd0);
        chk("rst_addr",      32'(d_addr),      32'd0);
        chk("rst_onehot",    32'(d_onehot),    32'd0);
        chk("rst_c_valid",   32'(c_out_valid), 32'd0);
`ifdef IDEC_ILLEGAL_TRAP_EN
        chk("rst_illegal",   32'(c_illegal),   32'd0);
`endif

        // 2: single instruction 8'hA7
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid",  32'(d_out_valid), 32'd1);
        chk("single_opcode", 32'(d_opcode),    32'd5);
        chk("single_addr",   32'(d_addr),      32'd7);
        chk("single_onehot", 32'(d_onehot),    32'h20);
        chk("single_count",  32'(d_count),     32'd1);
        tick();
        chk("single_drained", 32'(d_out_valid), 32'd0);

        // 3: backpressure, fill to 2 then drain in order
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 8'h21;
        tick();
        chk("bp_ready_occ1", 32'(d_in_ready), 32'd1);
        instr = 8'h42;
        tick();
        chk("bp_ready_full", 32'(d_in_ready), 32'd0);
        instr = 8'h63;
        tick();
        chk("bp_ready_held", 32'(d_in_ready), 32'd0);
        chk("bp_count2",     32'(d_count),    32'd2);
        chk("bp_head0_op",   32'(d_opcode),   32'd1);
        chk("bp_head0_addr", 32'(d_addr),     32'd1);
        chk("bp_head0_oh",   32'(d_onehot),   32'h02);
        out_ready = 1'b1;
        tick();
        chk("bp_head1_op",   32'(d_opcode),   32'd2);
        chk("bp_head1_addr", 32'(d_addr),     32'd2);
        chk("bp_ready_free", 32'(d_in_ready), 32'd1);
        chk("bp_count_hold", 32'(d_count),    32'd2);
        tick();
        in_valid = 1'b0;
        chk("bp_head2_op",   32'(d_opcode),   32'd3);
        chk("bp_head2_addr", 32'(d_addr),     32'd3);
        chk("bp_count3",     32'(d_count),    32'd3);
        chk("bp_valid2",     32'(d_out_valid), 32'd1);
        tick();
        chk("bp_empty",      32'(d_out_valid), 32'd0);

        // 4: continuous stream, 20 words, push+pop each cycle
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr = {3'(i % 6), 5'(i)};
            tick();
            chk($sformatf("str_valid_%0d", i), 32'(d_out_valid), 32'd1);
            chk($sformatf("str_ready_%0d", i), 32'(d_in_ready),  32'd1);
            chk($sformatf("str_op_%0d", i),    32'(d_opcode),    32'(i % 6));
            chk($sformatf("str_addr_%0d", i),  32'(d_addr),      32'(i));
            chk($sformatf("str_oh_%0d", i),    32'(d_onehot),    32'd1 << (i % 6));
        end
        in_valid = 1'b0;
        chk("str_count",   32'(d_count), 32'd20);
        chk("str_c_count", 32'(c_count), 32'd4);
        tick();
        chk("str_drained", 32'(d_out_valid), 32'd0);

        // 5: 4-bit counter wrap, then en=0 freezes input while buffer drains
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            instr = {3'(i % 6), 5'(i)};
            tick();
        end
        chk("wrap_c_count", 32'(c_count), 32'd1);
        chk("wrap_d_count", 32'(d_count), 32'd17);
        out_ready = 1'b0; en = 1'b0;
        #1;
        chk("en0_ready", 32'(c_in_ready), 32'd0);
        tick(); tick();
        chk("en0_count_frozen", 32'(c_count),     32'd1);
        chk("en0_valid_held",   32'(c_out_valid), 32'd1);
        chk("en0_head_op",      32'(c_opcode),    32'd4);
        chk("en0_head_addr",    32'(c_addr),      32'd16);
        out_ready = 1'b1;
        tick();
        chk("en0_drained",      32'(c_out_valid), 32'd0);
        chk("en0_count_final",  32'(c_count),     32'd1);
        in_valid = 1'b0; en = 1'b1;

        // 6: opcode 7 with NUM_OPS=6
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 8'hE0;
        tick();
        in_valid = 1'b0;
        chk("ill_c_valid",  32'(c_out_valid), 32'd1);
        chk("ill_c_opcode", 32'(c_opcode),    32'd7);
        chk("ill_c_onehot", 32'(c_onehot),    32'd0);
        chk("ill_d_onehot", 32'(d_onehot),    32'h80);
`ifdef IDEC_ILLEGAL_TRAP_EN
        chk("ill_c_flag",   32'(c_illegal),   32'd1);
        chk("ill_c_ready",  32'(c_in_ready),  32'd0);
        chk("ill_d_flag",   32'(d_illegal),   32'd0);
        chk("ill_d_ready",  32'(d_in_ready),  32'd1);
        out_ready = 1'b1;
        tick();
        chk("ill_drained",     32'(c_out_valid), 32'd0);
        chk("ill_ready_stuck", 32'(c_in_ready),  32'd0);
        chk("ill_flag_stuck",  32'(c_illegal),   32'd1);
        do_reset();
        #1;
        chk("ill_flag_cleared", 32'(c_illegal),  32'd0);
        chk("ill_ready_back",   32'(c_in_ready), 32'd1);
`else
        chk("ill_c_ready",  32'(c_in_ready),  32'd1);
        out_ready = 1'b1;
        tick();
        chk("ill_drained",  32'(c_out_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
